// File: rtl/alu_execute_stage_pkg.sv
// Shared types and constants for the RV32 execute stage: ALU function codes,
// operand-2 source selects and the datapath width.
package alu_execute_stage_pkg;

    localparam int XLEN = 32;

    typedef enum logic [1:0] {
        ALU_ADD = 2'b00,
        ALU_SUB = 2'b01,
        ALU_SLL = 2'b10,
        ALU_SRL = 2'b11
    } alu_op_e;

    typedef enum logic [2:0] {
        OP2_RS2   = 3'b000,
        OP2_IMMI  = 3'b001,
        OP2_IMMS  = 3'b010,
        OP2_SHAMT = 3'b011,
        OP2_IMMU  = 3'b100
    } op2_sel_e;

    function automatic logic [XLEN-1:0] sext12(input logic [11:0] value);
        return {{(XLEN-12){value[11]}}, value};
    endfunction

endpackage

// File: rtl/alu_execute_stage_if.sv
// Control, operand and result bundle between the control unit / register file
// and the execute stage.
interface alu_execute_stage_if import alu_execute_stage_pkg::*; ();

    logic                   muxrs1;
    logic [1:0]             alu_op;
    logic [2:0]             op2_sel;
    logic [XLEN-1:0]        zero;
    logic [XLEN-1:0]        rs1;
    logic [XLEN-1:0]        rs2;
    logic [6:0]             imm_7;
    logic [4:0]             imm_5;
    logic [11:0]            imm_12;
    logic [4:0]             shamt_5;
    logic [19:0]            imm_20;
    logic signed [XLEN-1:0] operand1;
    logic signed [XLEN-1:0] operand2;
    logic [XLEN-1:0]        result;

    modport master (
        output muxrs1, alu_op, op2_sel, zero, rs1, rs2,
               imm_7, imm_5, imm_12, shamt_5, imm_20,
        input  operand1, operand2, result
    );

    modport slave (
        input  muxrs1, alu_op, op2_sel, zero, rs1, rs2,
               imm_7, imm_5, imm_12, shamt_5, imm_20,
        output operand1, operand2, result
    );

endinterface

// File: rtl/alu_operand2_gen.sv
// Builds the RV32 immediates from raw instruction fields and selects the
// second ALU operand.
module alu_operand2_gen import alu_execute_stage_pkg::*; (
    input  logic [2:0]      op2_sel,
    input  logic [XLEN-1:0] rs2,
    input  logic [6:0]      imm_7,
    input  logic [4:0]      imm_5,
    input  logic [11:0]     imm_12,
    input  logic [4:0]      shamt_5,
    input  logic [19:0]     imm_20,
    output logic [XLEN-1:0] operand2
);

    logic [XLEN-1:0] imm_i;
    logic [XLEN-1:0] imm_s;
    logic [XLEN-1:0] imm_shamt;
    logic [XLEN-1:0] imm_u;

    assign imm_i     = sext12(imm_12);
    assign imm_s     = sext12({imm_7, imm_5});
    assign imm_shamt = {{(XLEN-5){1'b0}}, shamt_5};
    assign imm_u     = {imm_20, 12'b0};

    always_comb begin
        // NOTE: default assignment first so no path through the case leaves operand2 unassigned (no latch).
        operand2 = '0;
        case (op2_sel_e'(op2_sel))
            OP2_RS2:   operand2 = rs2;
            OP2_IMMI:  operand2 = imm_i;
            OP2_IMMS:  operand2 = imm_s;
            OP2_SHAMT: operand2 = imm_shamt;
            OP2_IMMU:  operand2 = imm_u;
            default:   operand2 = '0;
        endcase
    end

endmodule

// File: rtl/alu_execute_stage.sv
// Execute stage: operand-1 select, operand-2 generation and a 4-function ALU
// whose result is registered for the memory address / writeback paths.
module alu_execute_stage import alu_execute_stage_pkg::*; (
    input logic                clock,
    input logic                Reset,
    alu_execute_stage_if.slave bus
);

    logic [XLEN-1:0] op1;
    logic [XLEN-1:0] op2;
    logic [XLEN-1:0] alu_out;
    logic [XLEN-1:0] result_q;
    logic [4:0]      shift_amount;

    // Hard-zero is taken from the register file so LUI-style ops reuse the adder.
    assign op1 = bus.muxrs1 ? bus.zero : bus.rs1;

    alu_operand2_gen u_operand2_gen (
        .op2_sel  (bus.op2_sel),
        .rs2      (bus.rs2),
        .imm_7    (bus.imm_7),
        .imm_5    (bus.imm_5),
        .imm_12   (bus.imm_12),
        .shamt_5  (bus.shamt_5),
        .imm_20   (bus.imm_20),
        .operand2 (op2)
    );

    assign shift_amount = op2[4:0];

    always_comb begin
        alu_out = '0;
        case (alu_op_e'(bus.alu_op))
            ALU_ADD: alu_out = op1 + op2;
            ALU_SUB: alu_out = op1 - op2;
            ALU_SLL: alu_out = op1 << shift_amount;
            ALU_SRL: alu_out = op1 >> shift_amount;
            default: alu_out = '0;
        endcase
    end

    always_ff @(posedge clock or posedge Reset) begin
        // NOTE: non-blocking assignment for registered state avoids ordering races between clocked blocks.
        if (Reset) begin
            result_q <= '0;
        end else begin
            result_q <= alu_out;
        end
    end

    assign bus.operand1 = op1;
    assign bus.operand2 = op2;
    assign bus.result   = result_q;

endmodule

// File: tb/tb_alu_execute_stage.sv
// Self-checking bench for alu_execute_stage: directed spec vectors plus random
// traffic against an arithmetic reference model.
module tb_alu_execute_stage;
    import alu_execute_stage_pkg::*;

    typedef struct packed {
        logic        muxrs1;
        logic [1:0]  alu_op;
        logic [2:0]  op2_sel;
        logic [31:0] zero;
        logic [31:0] rs1;
        logic [31:0] rs2;
        logic [6:0]  imm_7;
        logic [4:0]  imm_5;
        logic [11:0] imm_12;
        logic [4:0]  shamt_5;
        logic [19:0] imm_20;
    } stim_t;

    localparam longint MOD = 64'h1_0000_0000;

    logic clock = 1'b0;
    logic Reset = 1'b1;
    int   total = 0;
    int   bad   = 0;

    alu_execute_stage_if bus ();

    alu_execute_stage dut (
        .clock (clock),
        .Reset (Reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    // ---------------- reference model ----------------
    function automatic logic [31:0] model_op1(input stim_t s);
        return s.muxrs1 ? s.zero : s.rs1;
    endfunction

    function automatic logic [31:0] model_op2(input stim_t s);
        longint v;
        case (s.op2_sel)
            3'd0: v = s.rs2;
            3'd1: begin
                v = s.imm_12;
                if (v >= 2048) v = v - 4096;
            end
            3'd2: begin
                v = longint'(s.imm_7) * 32 + longint'(s.imm_5);
                if (v >= 2048) v = v - 4096;
            end
            3'd3: v = s.shamt_5;
            3'd4: v = longint'(s.imm_20) * 4096;
            default: v = 0;
        endcase
        v = ((v % MOD) + MOD) % MOD;
        return v[31:0];
    endfunction

    function automatic logic [31:0] model_result(input stim_t s);
        longint a = model_op1(s);
        longint b = model_op2(s);
        longint p = 1;
        longint r;
        for (int k = 0; k < int'(b % 32); k++) p = p * 2;
        case (s.alu_op)
            2'd0:    r = (a + b) % MOD;
            2'd1:    r = (a - b + MOD) % MOD;
            2'd2:    r = (a * p) % MOD;
            default: r = a / p;
        endcase
        return r[31:0];
    endfunction

    // ---------------- stimulus helpers ----------------
    function automatic stim_t blank();
        stim_t s;
        s = '0;
        return s;
    endfunction

    function automatic stim_t rand_stim();
        stim_t s;
        s.muxrs1  = 1'($urandom_range(0, 3) == 0);
        s.alu_op  = 2'($urandom);
        s.op2_sel = 3'($urandom);
        s.zero    = ($urandom_range(0, 3) == 0) ? $urandom : 32'h0;
        s.rs1     = $urandom;
        s.rs2     = $urandom;
        s.imm_7   = 7'($urandom);
        s.imm_5   = 5'($urandom);
        s.imm_12  = 12'($urandom);
        s.shamt_5 = 5'($urandom);
        s.imm_20  = 20'($urandom);
        return s;
    endfunction

    task automatic drive(input stim_t s);
        bus.muxrs1  = s.muxrs1;
        bus.alu_op  = s.alu_op;
        bus.op2_sel = s.op2_sel;
        bus.zero    = s.zero;
        bus.rs1     = s.rs1;
        bus.rs2     = s.rs2;
        bus.imm_7   = s.imm_7;
        bus.imm_5   = s.imm_5;
        bus.imm_12  = s.imm_12;
        bus.shamt_5 = s.shamt_5;
        bus.imm_20  = s.imm_20;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        stim_t s = blank();
        s.rs1 = 32'd5;
        s.rs2 = 32'd7;
        drive(s);
        @(posedge clock); #1;
        total++;
        if (bus.result !== 32'h0) begin
            bad++; $display("FAIL reset_held result=%h expected=%h", bus.result, 32'h0);
        end
        bus.rs1 = 32'd9; #1;
        total++;
        if (bus.operand1 !== 32'd9) begin
            bad++; $display("FAIL reset_op1_tracks operand1=%h expected=%h", bus.operand1, 32'd9);
        end
        bus.rs1 = 32'd5;
        @(negedge clock); Reset = 1'b0;
        @(posedge clock); #1;
        total++;
        if (bus.result !== 32'd12) begin
            bad++; $display("FAIL reset_release result=%h expected=%h", bus.result, 32'd12);
        end
        @(negedge clock); #2; Reset = 1'b1; #1;
        total++;
        if (bus.result !== 32'h0) begin
            bad++; $display("FAIL reset_async result=%h expected=%h", bus.result, 32'h0);
        end
        @(posedge clock); #1;
        total++;
        if (bus.result !== 32'h0) begin
            bad++; $display("FAIL reset_hold_edge result=%h expected=%h", bus.result, 32'h0);
        end
        @(negedge clock); Reset = 1'b0;
        @(posedge clock); #1;
        total++;
        if (bus.result !== 32'd12) begin
            bad++; $display("FAIL reset_release2 result=%h expected=%h", bus.result, 32'd12);
        end
    endtask

    task automatic test_imm_i();
        stim_t       s[2];
        logic [31:0] e_op2[2];
        logic [31:0] e_res[2];
        s[0] = blank(); s[0].rs1 = 32'h10;       s[0].op2_sel = 3'b001; s[0].imm_12 = 12'hFFF;
        s[1] = blank(); s[1].rs1 = 32'hFFFF_FFFF; s[1].op2_sel = 3'b001; s[1].imm_12 = 12'h001;
        e_op2[0] = 32'hFFFF_FFFF; e_res[0] = 32'h0000_000F;
        e_op2[1] = 32'h0000_0001; e_res[1] = 32'h0000_0000;
        for (int i = 0; i < 2; i++) begin
            @(negedge clock); drive(s[i]); #1;
            total++;
            if (bus.operand2 !== e_op2[i]) begin
                bad++; $display("FAIL imm_i_op2[%0d] operand2=%h expected=%h", i, bus.operand2, e_op2[i]);
            end
            @(posedge clock); #1;
            total++;
            if (bus.result !== e_res[i]) begin
                bad++; $display("FAIL imm_i_result[%0d] result=%h expected=%h", i, bus.result, e_res[i]);
            end
        end
    endtask

    task automatic test_imm_s();
        stim_t s = blank();
        s.rs1 = 32'h100; s.imm_7 = 7'h7F; s.imm_5 = 5'h1C; s.op2_sel = 3'b010;
        @(negedge clock); drive(s); #1;
        total++;
        if (bus.operand2 !== 32'hFFFF_FFFC) begin
            bad++; $display("FAIL imm_s_op2 operand2=%h expected=%h", bus.operand2, 32'hFFFF_FFFC);
        end
        @(posedge clock); #1;
        total++;
        if (bus.result !== 32'h0000_00FC) begin
            bad++; $display("FAIL imm_s_result result=%h expected=%h", bus.result, 32'h0000_00FC);
        end
    endtask

    task automatic test_lui();
        stim_t s = blank();
        s.muxrs1 = 1'b1; s.rs1 = 32'h1234_5678; s.imm_20 = 20'hABCDE; s.op2_sel = 3'b100;
        @(negedge clock); drive(s); #1;
        total++;
        if (bus.operand1 !== 32'h0) begin
            bad++; $display("FAIL lui_op1 operand1=%h expected=%h", bus.operand1, 32'h0);
        end
        total++;
        if (bus.operand2 !== 32'hABCD_E000) begin
            bad++; $display("FAIL lui_op2 operand2=%h expected=%h", bus.operand2, 32'hABCD_E000);
        end
        @(posedge clock); #1;
        total++;
        if (bus.result !== 32'hABCD_E000) begin
            bad++; $display("FAIL lui_result result=%h expected=%h", bus.result, 32'hABCD_E000);
        end
    endtask

    task automatic test_sub_shift();
        stim_t       s[3];
        logic [31:0] e_res[3];
        s[0] = blank(); s[0].rs1 = 32'd3; s[0].rs2 = 32'd5; s[0].alu_op = 2'b01;
        s[1] = blank(); s[1].rs1 = 32'h8000_0001; s[1].shamt_5 = 5'd4; s[1].op2_sel = 3'b011; s[1].alu_op = 2'b11;
        s[2] = blank(); s[2].rs1 = 32'h8000_0001; s[2].rs2 = 32'h0000_0021; s[2].alu_op = 2'b10;
        e_res[0] = 32'hFFFF_FFFE;
        e_res[1] = 32'h0800_0000;
        e_res[2] = 32'h0000_0002;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock); drive(s[i]);
            @(posedge clock); #1;
            total++;
            if (bus.result !== e_res[i]) begin
                bad++; $display("FAIL sub_shift[%0d] result=%h expected=%h", i, bus.result, e_res[i]);
            end
        end
    endtask

    task automatic test_unused_sel();
        stim_t s = blank();
        s.rs1 = 32'd9; s.rs2 = 32'hDEAD_BEEF; s.imm_12 = 12'h7FF; s.op2_sel = 3'b111;
        @(negedge clock); drive(s); #1;
        total++;
        if (bus.operand2 !== 32'h0) begin
            bad++; $display("FAIL unused_op2 operand2=%h expected=%h", bus.operand2, 32'h0);
        end
        @(posedge clock); #1;
        total++;
        if (bus.result !== 32'd9) begin
            bad++; $display("FAIL unused_result result=%h expected=%h", bus.result, 32'd9);
        end
    endtask

    // Inputs change right after every edge; each edge must show the previous cycle's op.
    task automatic test_back_to_back();
        stim_t       s;
        logic [31:0] expected;
        @(negedge clock);
        s = rand_stim(); drive(s); expected = model_result(s);
        for (int i = 0; i < 24; i++) begin
            @(posedge clock); #1;
            total++;
            if (bus.result !== expected) begin
                bad++; $display("FAIL back_to_back[%0d] result=%h expected=%h", i, bus.result, expected);
            end
            s = rand_stim(); s.alu_op = 2'(i); drive(s); expected = model_result(s);
        end
    endtask

    task automatic test_random();
        stim_t       s;
        logic [31:0] e1, e2, er;
        for (int i = 0; i < 300; i++) begin
            @(negedge clock);
            s = rand_stim(); drive(s); #1;
            e1 = model_op1(s); e2 = model_op2(s); er = model_result(s);
            total++;
            if (bus.operand1 !== e1) begin
                bad++; $display("FAIL random_op1[%0d] operand1=%h expected=%h", i, bus.operand1, e1);
            end
            total++;
            if (bus.operand2 !== e2) begin
                bad++; $display("FAIL random_op2[%0d] sel=%0d operand2=%h expected=%h", i, s.op2_sel, bus.operand2, e2);
            end
            @(posedge clock); #1;
            total++;
            if (bus.result !== er) begin
                bad++; $display("FAIL random_result[%0d] op=%0d result=%h expected=%h", i, s.alu_op, bus.result, er);
            end
        end
    endtask

    initial begin
        drive(blank());
        test_reset();
        test_imm_i();
        test_imm_s();
        test_lui();
        test_sub_shift();
        test_unused_sel();
        test_back_to_back();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/alu_execute_stage.md
Name: alu_execute_stage

Overview:
Execute-stage datapath of the multi-cycle RV32 core. It combines three pieces:
- operand-1 select (rs1 value or hard-zero, used for LUI-style ops);
- operand-2 select (rs2 or one of four immediate forms built from raw instruction fields);
- a 4-function integer ALU whose 32-bit result is registered.

It sits between the register file/control unit and data memory. The result drives the memory address and the writeback mux.

Parameters:
- XLEN, 32, datapath width. Only 32 is supported; immediate layouts assume RV32.

Ports:
- clock  in  1  rising-edge clock
- Reset  in  1  asynchronous, active-high reset
- muxrs1  in  1  operand-1 select: 0 = rs1, 1 = zero
- alu_op  in  2  ALU function code
- op2_sel  in  3  operand-2 source select
- zero  in  32  hard-zero value from register file (x0)
- rs1  in  32  register-file read data 1
- rs2  in  32  register-file read data 2
- imm_7  in  7  instr[31:25]
- imm_5  in  5  instr[11:7]
- imm_12  in  12  instr[31:20]
- shamt_5  in  5  instr[24:20]
- imm_20  in  20  instr[31:12]
- operand1  out  32  selected operand 1 (combinational, signed)
- operand2  out  32  selected operand 2 (combinational, signed)
- result  out  32  registered ALU result

Behaviour:
Operand 1 (combinational):
- operand1 = muxrs1 ? zero : rs1.

Operand 2 (combinational, by op2_sel):
- 000: rs2.
- 001: I-immediate, sign-extended imm_12 (bit 11 replicated into [31:12]).
- 010: S-immediate, sign-extended {imm_7, imm_5} (imm_7[6] is the sign bit).
- 011: shift amount, zero-extended shamt_5.
- 100: U-immediate, {imm_20, 12'b0}.
- 101..111: 32'h0000_0000.

ALU function (combinational, by alu_op):
- 00 ADD: operand1 + operand2, modulo 2^32, no overflow flag.
- 01 SUB: operand1 - operand2, modulo 2^32.
- 10 SLL: operand1 << operand2[4:0]; upper operand2 bits ignored.
- 11 SRL: logical operand1 >> operand2[4:0], zero fill.

Result register:
- result is loaded with the ALU function output on every rising clock edge.
- No enable. Latency is 1 cycle from stable inputs to result.
- Reset asserted forces result = 0 immediately (asynchronous) and holds it while asserted.
- Reset asserted mid-operation discards the pending value. The first rising edge after Reset deasserts captures the current inputs.
- operand1 and operand2 do not depend on Reset; they follow inputs combinationally.
- Reset value of every output: result = 0. operand1 and operand2 track their inputs even during reset.
- Any input change between edges affects only the next captured result; there is no glitch on result.

Decomposition:
- Shared package holds:
  - ALU op constants: ALU_ADD = 2'b00, ALU_SUB = 2'b01, ALU_SLL = 2'b10, ALU_SRL = 2'b11.
  - op2_sel constants: OP2_RS2, OP2_IMMI, OP2_IMMS, OP2_SHAMT, OP2_IMMU.
  - XLEN.
- One natural sub-module: alu_operand2_gen, holding the immediate build and the op2 mux. The operand-1 mux and the ALU stay inline.

Test Plan:
- Reset: assert Reset with clock running and inputs driving ADD 5+7 -> result = 0 asynchronously and holds 0. Deassert Reset -> next edge result = 12.
- ADD with I-immediate: rs1 = 32'h0000_0010, op2_sel = 001, imm_12 = 12'hFFF, alu_op = 00, muxrs1 = 0 -> operand2 = 32'hFFFF_FFFF; after 1 edge result = 32'h0000_000F. Also rs1 = 32'hFFFF_FFFF with imm_12 = 1 -> result = 0 (wrap).
- Store address with S-immediate: rs1 = 32'h100, imm_7 = 7'h7F, imm_5 = 5'h1C, op2_sel = 010, ADD -> operand2 = 32'hFFFF_FFFC, result = 32'h0000_00FC.
- LUI path: muxrs1 = 1, zero = 0, imm_20 = 20'hABCDE, op2_sel = 100, ADD -> result = 32'hABCD_E000, independent of rs1 = 32'h1234_5678.
- SUB and shifts:
  - rs1 = 3, rs2 = 5, SUB -> 32'hFFFF_FFFE.
  - rs1 = 32'h8000_0001, shamt_5 = 4, op2_sel = 011, SRL -> 32'h0800_0000.
  - SLL with rs2 = 32'h0000_0021 (shift by 1) on rs1 = 32'h8000_0001 -> 32'h0000_0002.
- Unused select: op2_sel = 111, rs1 = 9, ADD -> operand2 = 0, result = 9. Back-to-back op changes on consecutive edges each appear exactly one cycle later.
